// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default addresses for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [31:0] DEF_INIT_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEF_EXCPT_ADDR = 32'h0000_2000;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc, instr} entries with flush.
// Head is read from registered storage, so a push is visible one cycle later.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  fq_entry_t   data_i,
    output fq_entry_t   data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i & !flush_i & !full_o;
    assign do_pop  = pop_i & !flush_i & !empty_o;
    assign data_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;

    // Flush overrides any same-cycle push or pop.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop)
                rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding I-cache requester and fetch queue to ID.
// Define FETCH_PERF_EN to build the performance counters; otherwise they read 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          FQ_DEPTH   = 4,
    parameter logic [31:0] INIT_ADDR  = DEF_INIT_ADDR,
    parameter logic [31:0] EXCPT_ADDR = DEF_EXCPT_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        excpt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        ic_req_valid_o,
    output logic [31:0] ic_req_addr_o,
    input  logic        ic_req_ready_i,
    input  logic        ic_rsp_valid_i,
    input  logic [31:0] ic_rsp_instr_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    input  logic        id_ready_i,
    output logic [31:0] perf_icstall_o,
    output logic [31:0] perf_redirect_o,
    output logic [31:0] perf_starve_o
);
    localparam int AW = $clog2(FQ_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, req_pc_q;
    logic         flush, req_hs, push, full, empty;
    logic [AW:0]  count;
    fq_entry_t    head;

    assign flush  = excpt_i | redirect_i;
    // Space check ignores a same-cycle pop on purpose: it keeps the response path short.
    assign ic_req_valid_o = !flush & !reset &
        ((state_q == FETCH & !full) |
         (state_q == WAIT & ic_rsp_valid_i & count < (AW+1)'(FQ_DEPTH - 1)));
    assign ic_req_addr_o = pc_q;
    assign req_hs = ic_req_valid_o & ic_req_ready_i;
    assign push   = state_q == WAIT & ic_rsp_valid_i & !flush;
    assign pc_d   = excpt_i ? EXCPT_ADDR : redirect_i ? redirect_target_i : req_hs ? pc_q + 32'd4 : pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   state_d = req_hs ? WAIT : FETCH;
            WAIT:    state_d = ic_rsp_valid_i ? (req_hs ? WAIT : FETCH) : (flush ? DRAIN : WAIT);
            DRAIN:   state_d = ic_rsp_valid_i ? FETCH : DRAIN;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= INIT_ADDR;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (req_hs)
                req_pc_q <= pc_q;
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (id_valid_o & id_ready_i & !flush),
        .flush_i (flush),
        .data_i  ('{pc: req_pc_q, instr: ic_rsp_instr_i}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign id_valid_o = !empty;
    assign id_pc_o    = empty ? '0 : head.pc;
    assign id_instr_o = empty ? '0 : head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] icstall_q, redirect_q, starve_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            icstall_q  <= '0;
            redirect_q <= '0;
            starve_q   <= '0;
        end else begin
            icstall_q  <= icstall_q + {31'd0, state_q == WAIT & !ic_rsp_valid_i};
            redirect_q <= redirect_q + {31'd0, flush};
            starve_q   <= starve_q + {31'd0, !id_valid_o};
        end
    end
    assign perf_icstall_o  = icstall_q;
    assign perf_redirect_o = redirect_q;
    assign perf_starve_o   = starve_q;
`else
    assign perf_icstall_o  = '0;
    assign perf_redirect_o = '0;
    assign perf_starve_o   = '0;
`endif

    rsp_in_fetch: assert property (@(posedge clock) disable iff (reset) !(state_q == FETCH && ic_rsp_valid_i));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit against a single-outstanding I-cache model.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'h1357_9BDF;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1;
    logic        excpt_i = 1'b0, redirect_i = 1'b0, id_ready_i = 1'b1;
    logic [31:0] redirect_target_i = '0;
    logic        ic_req_valid_o, ic_req_ready_i = 1'b1, ic_rsp_valid_i = 1'b0;
    logic [31:0] ic_req_addr_o, ic_rsp_instr_i = '0;
    logic        id_valid_o;
    logic [31:0] id_pc_o, id_instr_o, perf_icstall_o, perf_redirect_o, perf_starve_o;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .excpt_i           (excpt_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .ic_req_valid_o    (ic_req_valid_o),
        .ic_req_addr_o     (ic_req_addr_o),
        .ic_req_ready_i    (ic_req_ready_i),
        .ic_rsp_valid_i    (ic_rsp_valid_i),
        .ic_rsp_instr_i    (ic_rsp_instr_i),
        .id_valid_o        (id_valid_o),
        .id_pc_o           (id_pc_o),
        .id_instr_o        (id_instr_o),
        .id_ready_i        (id_ready_i),
        .perf_icstall_o    (perf_icstall_o),
        .perf_redirect_o   (perf_redirect_o),
        .perf_starve_o     (perf_starve_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          first, exc, red;
        logic [31:0] tgt;
        bit          rdy;
        int          lat;
        bit          ev;
        logic [31:0] ea;
        bit          eidv;
        logic [31:0] epc;
    } vec_t;
    vec_t vecs[$];

    int          checks = 0, failures = 0;
    int          lat = 1, wcnt = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    logic        s_v, s_idv;
    logic [31:0] s_addr, s_idpc, s_idi, s_stall, s_redir, s_starve;

    task automatic add(bit first, bit exc, bit red, logic [31:0] tgt, bit rdy, int l,
                       bit ev, logic [31:0] ea, bit eidv, logic [31:0] epc);
        vec_t v;
        v.first = first; v.exc = exc; v.red = red; v.tgt = tgt; v.rdy = rdy; v.lat = l;
        v.ev = ev; v.ea = ea; v.eidv = eidv; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive cache response from the model, sample outputs, advance the model.
    task automatic tick();
        ic_rsp_valid_i = !reset && pend && wcnt == 0;
        ic_rsp_instr_i = pend_addr ^ K;
        #1;
        s_v = ic_req_valid_o; s_addr = ic_req_addr_o; s_idv = id_valid_o;
        s_idpc = id_pc_o; s_idi = id_instr_o;
        s_stall = perf_icstall_o; s_redir = perf_redirect_o; s_starve = perf_starve_o;
        if (reset) pend = 0;
        else begin
            if (ic_rsp_valid_i) pend = 0;
            else if (pend) wcnt--;
            if (s_v && ic_req_ready_i) begin
                pend = 1; wcnt = lat - 1; pend_addr = s_addr;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        excpt_i = 0; redirect_i = 0; id_ready_i = 1; pend = 0; reset = 1;
        tick();
        tick();
        chk("reset req_valid", {31'd0, s_v}, 32'd0);
        chk("reset req_addr", s_addr, 32'h1000);
        chk("reset id_valid", {31'd0, s_idv}, 32'd0);
        chk("reset id_pc", s_idpc, 32'd0);
        chk("reset perf_icstall", s_stall, 32'd0);
        chk("reset perf_redirect", s_redir, 32'd0);
        chk("reset perf_starve", s_starve, 32'd0);
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1-cycle hit, ID always ready
        add(1,0,0,0,1,1, 1,32'h1000,0,0);
        add(0,0,0,0,1,1, 1,32'h1004,0,0);
        add(0,0,0,0,1,1, 1,32'h1008,1,32'h1000);
        add(0,0,0,0,1,1, 1,32'h100C,1,32'h1004);
        add(0,0,0,0,1,1, 1,32'h1010,1,32'h1008);
        // ID stall for 10 cycles: queue fills to 4, then drains in order
        add(1,0,0,0,0,1, 1,32'h1000,0,0);
        add(0,0,0,0,0,1, 1,32'h1004,0,0);
        add(0,0,0,0,0,1, 1,32'h1008,1,32'h1000);
        add(0,0,0,0,0,1, 1,32'h100C,1,32'h1000);
        for (int i = 0; i < 6; i++) add(0,0,0,0,0,1, 0,32'h1010,1,32'h1000);
        add(0,0,0,0,1,1, 0,32'h1010,1,32'h1000);
        add(0,0,0,0,1,1, 1,32'h1010,1,32'h1004);
        add(0,0,0,0,1,1, 1,32'h1014,1,32'h1008);
        add(0,0,0,0,1,1, 1,32'h1018,1,32'h100C);
        add(0,0,0,0,1,1, 1,32'h101C,1,32'h1010);
        // 5-cycle miss
        add(1,0,0,0,1,5, 1,32'h1000,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0,1,5, 0,32'h1004,0,0);
        add(0,0,0,0,1,5, 1,32'h1004,0,0);
        add(0,0,0,0,1,5, 0,32'h1008,1,32'h1000);
        // redirect while waiting: stale 0x1004 response drained
        add(1,0,0,0,1,2, 1,32'h1000,0,0);
        add(0,0,0,0,1,2, 0,32'h1004,0,0);
        add(0,0,0,0,1,2, 1,32'h1004,0,0);
        add(0,0,1,32'h3000,1,2, 0,32'h1008,1,32'h1000);
        add(0,0,0,0,1,2, 0,32'h3000,0,0);
        add(0,0,0,0,1,2, 1,32'h3000,0,0);
        add(0,0,0,0,1,2, 0,32'h3004,0,0);
        add(0,0,0,0,1,2, 1,32'h3004,0,0);
        add(0,0,0,0,1,2, 0,32'h3008,1,32'h3000);
        // exception + redirect on a response cycle: exception wins
        add(1,0,0,0,1,1, 1,32'h1000,0,0);
        add(0,0,0,0,1,1, 1,32'h1004,0,0);
        add(0,1,1,32'h3000,1,1, 0,32'h1008,1,32'h1000);
        add(0,0,0,0,1,1, 1,32'h2000,0,0);
        add(0,0,0,0,1,1, 1,32'h2004,0,0);
        add(0,0,0,0,1,1, 1,32'h2008,1,32'h2000);
        // redirect on a response cycle
        add(1,0,0,0,1,1, 1,32'h1000,0,0);
        add(0,0,0,0,1,1, 1,32'h1004,0,0);
        add(0,0,1,32'h3000,1,1, 0,32'h1008,1,32'h1000);
        add(0,0,0,0,1,1, 1,32'h3000,0,0);
        add(0,0,0,0,1,1, 1,32'h3004,0,0);
        add(0,0,0,0,1,1, 1,32'h3008,1,32'h3000);
        // PC wrap at top of address space
        add(1,0,1,32'hFFFF_FFFC,1,1, 0,32'h1000,0,0);
        add(0,0,0,0,1,1, 1,32'hFFFF_FFFC,0,0);
        add(0,0,0,0,1,1, 1,32'h0000_0000,0,0);
        add(0,0,0,0,1,1, 1,32'h0000_0004,1,32'hFFFF_FFFC);

        foreach (vecs[i]) begin
            if (vecs[i].first) do_reset();
            excpt_i = vecs[i].exc; redirect_i = vecs[i].red;
            redirect_target_i = vecs[i].tgt; id_ready_i = vecs[i].rdy; lat = vecs[i].lat;
            tick();
            chk($sformatf("row%0d req_valid", i), {31'd0, s_v}, {31'd0, vecs[i].ev});
            chk($sformatf("row%0d req_addr", i), s_addr, vecs[i].ea);
            chk($sformatf("row%0d id_valid", i), {31'd0, s_idv}, {31'd0, vecs[i].eidv});
            chk($sformatf("row%0d id_pc", i), s_idpc, vecs[i].epc);
            chk($sformatf("row%0d id_instr", i), s_idi, vecs[i].eidv ? vecs[i].epc ^ K : 32'd0);
        end
        excpt_i = 0; redirect_i = 0;

        // performance counters across a 5-cycle miss and one redirect
        do_reset();
        lat = 5; id_ready_i = 1;
        repeat (6) tick();
        chk("perf_icstall after miss", s_stall, PERF ? 32'd4 : 32'd0);
        chk("perf_starve after miss", s_starve, PERF ? 32'd5 : 32'd0);
        redirect_i = 1; redirect_target_i = 32'h3000;
        tick();
        redirect_i = 0;
        tick();
        chk("perf_redirect after redirect", s_redir, PERF ? 32'd1 : 32'd0);
        chk("req_addr after redirect", s_addr, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
